// File: rtl/deser_rr_arbiter_pkg.sv
// Shared types and helpers for the serial-source round-robin arbiter.
// rr_winner is sized for the largest supported source count so callers can zero-extend into it.
package deser_arb_pkg;

  localparam int MAX_SRC   = 16;
  localparam int MAX_SRC_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;

  // First requester at or after ptr, wrapping within n_src lanes; 0 when nobody requests.
  function automatic logic [MAX_SRC_W-1:0] rr_winner(
    input logic [MAX_SRC-1:0]   req,
    input logic [MAX_SRC_W-1:0] ptr,
    input int                   n_src
  );
    logic [MAX_SRC_W-1:0] win;
    logic                 found;
    int                   idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_SRC; k++) begin
      idx = (int'(ptr) + k) % n_src;
      if (!found && (k < n_src) && req[idx[MAX_SRC_W-1:0]]) begin
        win   = idx[MAX_SRC_W-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/deser_rr_arbiter_if.sv
// Bus between N_SRC serial sources, the arbiter, and the downstream deserializer.
// The arbiter takes the slave view; the sources and deserializer together form the master.
interface deser_rr_arbiter_if #(
  parameter int N_SRC = 4
) ();
  localparam int SRC_W = $clog2(N_SRC);

  logic [N_SRC-1:0] req_i;
  logic [N_SRC-1:0] data_i;
  logic [N_SRC-1:0] data_val_i;
  logic [N_SRC-1:0] grant_o;
  logic [SRC_W-1:0] src_id_o;
  logic             data_o;
  logic             data_val_o;
  logic             word_done_o;
  logic             flush_o;
  logic             abort_o;
  logic             busy_o;

  modport slave (
    input  req_i, data_i, data_val_i,
    output grant_o, src_id_o, data_o, data_val_o, word_done_o, flush_o, abort_o, busy_o
  );

  modport master (
    output req_i, data_i, data_val_i,
    input  grant_o, src_id_o, data_o, data_val_o, word_done_o, flush_o, abort_o, busy_o
  );
endinterface

// File: rtl/deser_rr_arbiter_rr_picker.sv
// Combinational round-robin selector: request vector plus pointer in, one-hot winner,
// its index and an any-request flag out.
module rr_picker
  import deser_arb_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int SRC_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [SRC_W-1:0] ptr,
  output logic [N_SRC-1:0] winner_oh,
  output logic [SRC_W-1:0] winner_idx,
  output logic             any
);
  logic [MAX_SRC_W-1:0] win_full;

  assign win_full   = rr_winner(MAX_SRC'(req), MAX_SRC_W'(ptr), N_SRC);
  assign winner_idx = SRC_W'(win_full);
  assign any        = |req;

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_oh
    assign winner_oh[gi] = any && (winner_idx == SRC_W'(gi));
  end
endmodule

// File: rtl/deser_rr_arbiter.sv
// Round-robin share of one deserializer between N_SRC serial lanes: grants a lane for
// DATA_W valid bits, forwards them registered, and aborts with a flush pulse if the lane stalls.
module deser_rr_arbiter
  import deser_arb_pkg::*;
#(
  parameter int N_SRC       = 4,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input logic               clk_i,
  input logic               srst_i,
  deser_rr_arbiter_if.slave bus
);
  localparam int SRC_W = $clog2(N_SRC);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [SRC_W-1:0] SRC_LAST = SRC_W'(N_SRC - 1);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_RUN   = ST_RUN;
  localparam logic [1:0] S_ABORT = ST_ABORT;

  logic [1:0]       state_reg;
  logic [SRC_W-1:0] ptr_reg;
  logic [N_SRC-1:0] grant_reg;
  logic [SRC_W-1:0] src_id_reg;
  logic [BIT_W-1:0] bit_cnt_reg;
  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             data_reg;
  logic             data_val_reg;
  logic             word_done_reg;
  logic             flush_reg;
  logic             abort_reg;

  logic [N_SRC-1:0] pick_oh;
  logic [SRC_W-1:0] pick_idx;
  logic             pick_any;
  logic             lane_val_next;
  logic             lane_dat_next;
  logic [SRC_W-1:0] ptr_adv_next;

  rr_picker #(
    .N_SRC (N_SRC),
    .SRC_W (SRC_W)
  ) u_picker (
    .req        (bus.req_i),
    .ptr        (ptr_reg),
    .winner_oh  (pick_oh),
    .winner_idx (pick_idx),
    .any        (pick_any)
  );

  // grant_reg is only non-zero in RUN, so masking with it selects the granted lane alone.
  assign lane_val_next = |(bus.data_val_i & grant_reg);
  assign lane_dat_next = |(bus.data_i & grant_reg);
  assign ptr_adv_next  = (src_id_reg == SRC_LAST) ? '0 : src_id_reg + SRC_W'(1);

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_reg     <= S_IDLE;
      ptr_reg       <= '0;
      grant_reg     <= '0;
      src_id_reg    <= '0;
      bit_cnt_reg   <= '0;
      tmo_cnt_reg   <= '0;
      data_reg      <= 1'b0;
      data_val_reg  <= 1'b0;
      word_done_reg <= 1'b0;
      flush_reg     <= 1'b0;
      abort_reg     <= 1'b0;
    end else begin
      data_val_reg  <= 1'b0;
      word_done_reg <= 1'b0;
      flush_reg     <= 1'b0;
      abort_reg     <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (pick_any) begin
            state_reg   <= S_RUN;
            grant_reg   <= pick_oh;
            src_id_reg  <= pick_idx;
            bit_cnt_reg <= '0;
            tmo_cnt_reg <= '0;
          end
        end
        S_RUN: begin
          data_reg     <= lane_dat_next;
          data_val_reg <= lane_val_next;
          if (lane_val_next) begin
            tmo_cnt_reg <= '0;
            if (bit_cnt_reg == BIT_LAST) begin
              state_reg     <= S_IDLE;
              grant_reg     <= '0;
              ptr_reg       <= ptr_adv_next;
              bit_cnt_reg   <= '0;
              word_done_reg <= 1'b1;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
            end
          end else if (tmo_cnt_reg == TMO_LAST) begin
            state_reg <= S_ABORT;
            grant_reg <= '0;
            flush_reg <= 1'b1;
            abort_reg <= 1'b1;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
          end
        end
        S_ABORT: begin
          state_reg   <= S_IDLE;
          ptr_reg     <= ptr_adv_next;
          bit_cnt_reg <= '0;
          tmo_cnt_reg <= '0;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.grant_o     = grant_reg;
  assign bus.src_id_o    = src_id_reg;
  assign bus.data_o      = data_reg;
  assign bus.data_val_o  = data_val_reg;
  assign bus.word_done_o = word_done_reg;
  assign bus.flush_o     = flush_reg;
  assign bus.abort_o     = abort_reg;
  assign bus.busy_o      = (state_reg == S_RUN);
endmodule
